// File: rtl/instr_encoder_loader_if.sv
// Micro-op handshake and instruction-memory write bus for the encoder/loader.
// The master is the stimulus source. The slave is the encoder, which also
// drives the memory write port.
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 8
);
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [12:0]       imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output op_valid, op_code, rd, rs1, rs2, imm,
      input  op_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  op_valid, op_code, rd, rs1, rs2, imm,
      output op_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and program loader.
// Symbolic micro-ops arrive over a valid/ready handshake. Each one is encoded
// into a 32-bit word and written to consecutive instruction-memory addresses.
// The encoder accepts at most one op every two cycles.
module instr_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int BASE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   instr_encoder_loader_if.slave bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [ADDR_W:0]       count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_XOR  = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_BNE  = 3'b110;
   localparam logic [2:0] OP_END  = 3'b111;

   localparam logic [1:0] ERR_IMM  = 2'b01;
   localparam logic [1:0] ERR_FULL = 2'b10;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

   state_t      state;
   logic [31:0] enc_word;
   logic        imm_ok;

   // Encode the presented micro-op and judge whether its immediate fits the format.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      enc_word = '0;
      imm_ok   = 1'b1;
      case (bus.op_code)
         OP_ADD:  enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
         OP_XOR:  enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b100, bus.rd, 7'b0110011};
         OP_SLL:  enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b001, bus.rd, 7'b0110011};
         OP_ADDI: begin
            // A 12-bit signed immediate is legal only when imm[12] is a copy of imm[11].
            imm_ok   = (bus.imm[12] == bus.imm[11]);
            enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
         end
         OP_LW: begin
            imm_ok   = (bus.imm[12] == bus.imm[11]);
            enc_word = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
         end
         OP_SW: begin
            imm_ok   = (bus.imm[12] == bus.imm[11]);
            enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
         end
         OP_BNE: begin
            // Every 13-bit value is in range; the branch offset only has to be even.
            imm_ok   = ~bus.imm[0];
            enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b001,
                        bus.imm[4:1], bus.imm[11], 7'b1100011};
         end
         default: ;
      endcase
   end

   // Load-session FSM. Every output is a register that is updated with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state is assigned with <= so all registers update together at the edge.
         state         <= S_IDLE;
         bus.op_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= BASE_C;
         bus.mem_wdata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= 2'b00;
         count         <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state        <= S_ACCEPT;
                  bus.op_ready <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  err_code     <= 2'b00;
                  count        <= '0;
                  bus.mem_addr <= BASE_C;
               end
            end
            S_ACCEPT: begin
               if (bus.op_valid && bus.op_ready) begin
                  bus.op_ready <= 1'b0;
                  if (bus.op_code == OP_END) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else if (count == DEPTH_C) begin
                     state    <= S_ERROR;
                     err      <= 1'b1;
                     err_code <= ERR_FULL;
                     busy     <= 1'b0;
                  end else if (!imm_ok) begin
                     state    <= S_ERROR;
                     err      <= 1'b1;
                     err_code <= ERR_IMM;
                     busy     <= 1'b0;
                  end else begin
                     state         <= S_WRITE;
                     bus.mem_wdata <= enc_word;
                     bus.mem_we    <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               // The address wraps modulo 2^ADDR_W when BASE+DEPTH exceeds the address space.
               state        <= S_ACCEPT;
               bus.mem_we   <= 1'b0;
               bus.mem_addr <= bus.mem_addr + 1'b1;
               count        <= count + 1'b1;
               bus.op_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader.
// Two instances share the stimulus: dut_a uses DEPTH=256 and dut_b uses DEPTH=2.
// Expected writes are queued when an op is driven and popped when mem_we is seen.
module tb_instr_encoder_loader;

   localparam int ADDR_W = 8;

   localparam logic [2:0] ADD  = 3'd0;
   localparam logic [2:0] XOR  = 3'd1;
   localparam logic [2:0] SLL  = 3'd2;
   localparam logic [2:0] ADDI = 3'd3;
   localparam logic [2:0] LW   = 3'd4;
   localparam logic [2:0] SW   = 3'd5;
   localparam logic [2:0] BNE  = 3'd6;
   localparam logic [2:0] ENDO = 3'd7;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        start;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [4:0]  rd, rs1, rs2;
   logic [12:0] imm;

   logic              busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [1:0]        ec_a, ec_b;
   logic [ADDR_W:0]   cnt_a, cnt_b;
   logic              start_a, start_b;

   logic              obs_ready, obs_we, obs_busy, obs_done, obs_err;
   logic [1:0]        obs_ec;
   logic [ADDR_W:0]   obs_cnt;
   logic [ADDR_W-1:0] obs_addr;
   logic [31:0]       obs_wdata;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  next_addr;

   always #5 clk = ~clk;

   instr_encoder_loader_if #(.ADDR_W(ADDR_W)) ifa ();
   instr_encoder_loader_if #(.ADDR_W(ADDR_W)) ifb ();

   assign start_a      = start & ~sel;
   assign start_b      = start & sel;
   assign ifa.op_valid = op_valid & ~sel;
   assign ifb.op_valid = op_valid & sel;
   assign ifa.op_code  = op_code;
   assign ifb.op_code  = op_code;
   assign ifa.rd       = rd;
   assign ifb.rd       = rd;
   assign ifa.rs1      = rs1;
   assign ifb.rs1      = rs1;
   assign ifa.rs2      = rs2;
   assign ifb.rs2      = rs2;
   assign ifa.imm      = imm;
   assign ifb.imm      = imm;

   assign obs_ready = sel ? ifb.op_ready  : ifa.op_ready;
   assign obs_we    = sel ? ifb.mem_we    : ifa.mem_we;
   assign obs_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
   assign obs_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;
   assign obs_busy  = sel ? busy_b : busy_a;
   assign obs_done  = sel ? done_b : done_a;
   assign obs_err   = sel ? err_b  : err_a;
   assign obs_ec    = sel ? ec_b   : ec_a;
   assign obs_cnt   = sel ? cnt_b  : cnt_a;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(256), .BASE(0)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
      .busy(busy_a), .done(done_a), .err(err_a), .err_code(ec_a), .count(cnt_a)
   );

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(2), .BASE(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
      .busy(busy_b), .done(done_b), .err(err_b), .err_code(ec_b), .count(cnt_b)
   );

   // Pulse start on the selected instance, then check the fresh session state.
   task automatic do_start(input bit s);
      @(negedge clk);
      sel   = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      next_addr = 0;
      @(negedge clk);
      checks++;
      if ({obs_ready, obs_busy, obs_done, obs_err, obs_ec, obs_cnt, obs_addr} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 9'd0, 8'd0})
         begin
            failures++;
            $display("FAIL start_state: got rdy=%b busy=%b done=%b err=%b ec=%b cnt=%0d addr=%0d expected 1 1 0 0 00 0 0",
                     obs_ready, obs_busy, obs_done, obs_err, obs_ec, obs_cnt, obs_addr);
         end
   endtask

   // Drive one micro-op and check the write that follows it, or its absence.
   task automatic send_op(input bit s, input logic [2:0] oc, input logic [4:0] d,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [12:0] im,
                          input bit wr, input logic [31:0] exp_data, output int waits);
      wr_t e, got;
      sel     = s;
      op_code = oc;
      rd      = d;
      rs1     = r1;
      rs2     = r2;
      imm     = im;
      if (wr) begin
         e.addr = ADDR_W'(next_addr);
         e.data = exp_data;
         exp_q.push_back(e);
         next_addr++;
      end
      op_valid = 1'b1;
      waits    = 0;
      while (obs_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (obs_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout: op=%0d op_ready=%b expected 1 within 20 cycles", oc, obs_ready);
         op_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_we !== wr) begin
         failures++;
         $display("FAIL mem_we_after_op: op=%0d got %b expected %b", oc, obs_we, wr);
      end
      if (wr) begin
         e         = exp_q.pop_front();
         got.addr  = obs_addr;
         got.data  = obs_wdata;
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL write_word: op=%0d got addr=%0d data=%h expected addr=%0d data=%h",
                     oc, got.addr, got.data, e.addr, e.data);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 1'b0; start = 1'b0; op_valid = 1'b1;
      op_code = ADD; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd0;
      #12;
      checks++;
      if ({ifa.op_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, busy_a, done_a, err_a, ec_a, cnt_a} !== '0) begin
         failures++;
         $display("FAIL reset_a: got rdy=%b we=%b addr=%0d wdata=%h busy=%b done=%b err=%b ec=%b cnt=%0d expected all 0",
                  ifa.op_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, busy_a, done_a, err_a, ec_a, cnt_a);
      end
      checks++;
      if ({ifb.op_ready, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, busy_b, done_b, err_b, ec_b, cnt_b} !== '0) begin
         failures++;
         $display("FAIL reset_b: got rdy=%b we=%b addr=%0d busy=%b cnt=%0d expected all 0",
                  ifb.op_ready, ifb.mem_we, ifb.mem_addr, busy_b, cnt_b);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifa.op_ready, ifa.mem_we, busy_a} !== 3'b000) begin
         failures++;
         $display("FAIL idle_no_start: got rdy=%b we=%b busy=%b expected 0 0 0", ifa.op_ready, ifa.mem_we, busy_a);
      end
      op_valid = 1'b0;
   endtask

   task automatic test_rtype();
      int w;
      do_start(1'b0);
      send_op(1'b0, ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3, w);
      send_op(1'b0, XOR, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h0020C1B3, w);
      send_op(1'b0, ENDO, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'h0, w);
      checks++;
      if ({obs_done, obs_err, obs_ec, obs_cnt, obs_busy, obs_ready} !== {1'b1, 1'b0, 2'b00, 9'd2, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rtype_done: got done=%b err=%b ec=%b cnt=%0d busy=%b rdy=%b expected 1 0 00 2 0 0",
                  obs_done, obs_err, obs_ec, obs_cnt, obs_busy, obs_ready);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({obs_addr, obs_wdata, obs_we} !== {8'd2, 32'h0020C1B3, 1'b0}) begin
         failures++;
         $display("FAIL done_hold: got addr=%0d wdata=%h we=%b expected 2 0020c1b3 0", obs_addr, obs_wdata, obs_we);
      end
   endtask

   task automatic test_itype();
      int w;
      do_start(1'b0);
      send_op(1'b0, ADDI, 5'd3, 5'd1, 5'd0, 13'd7, 1'b1, 32'h00708193, w);
      send_op(1'b0, LW, 5'd2, 5'd0, 5'd0, 13'd0, 1'b1, 32'h00002103, w);
      send_op(1'b0, SW, 5'd0, 5'd0, 5'd2, 13'd4, 1'b1, 32'h00202223, w);
      send_op(1'b0, ADDI, 5'd5, 5'd6, 5'd0, 13'h1FFF, 1'b1, 32'hFFF30293, w);
      send_op(1'b0, SLL, 5'd1, 5'd2, 5'd3, 13'd0, 1'b1, 32'h003110B3, w);
      send_op(1'b0, ENDO, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'h0, w);
      checks++;
      if ({obs_done, obs_cnt} !== {1'b1, 9'd5}) begin
         failures++;
         $display("FAIL itype_done: got done=%b cnt=%0d expected 1 5", obs_done, obs_cnt);
      end
   endtask

   task automatic test_branch();
      int w;
      do_start(1'b0);
      send_op(1'b0, BNE, 5'd0, 5'd1, 5'd2, 13'd0, 1'b1, 32'h00209063, w);
      send_op(1'b0, BNE, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1, 32'hFE209EE3, w);
      send_op(1'b0, BNE, 5'd0, 5'd1, 5'd2, 13'h1000, 1'b1, 32'h80209063, w);
      send_op(1'b0, ENDO, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'h0, w);
   endtask

   task automatic test_imm_errors();
      int w;
      do_start(1'b0);
      send_op(1'b0, ADDI, 5'd3, 5'd1, 5'd0, 13'h0800, 1'b0, 32'h0, w);
      checks++;
      if ({obs_done, obs_err, obs_ec, obs_cnt, obs_busy, obs_ready} !== {1'b0, 1'b1, 2'b01, 9'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL addi_range_err: got done=%b err=%b ec=%b cnt=%0d busy=%b rdy=%b expected 0 1 01 0 0 0",
                  obs_done, obs_err, obs_ec, obs_cnt, obs_busy, obs_ready);
      end
      do_start(1'b0);
      send_op(1'b0, ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3, w);
      send_op(1'b0, BNE, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 32'h0, w);
      checks++;
      if ({obs_err, obs_ec, obs_cnt} !== {1'b1, 2'b01, 9'd1}) begin
         failures++;
         $display("FAIL bne_odd_err: got err=%b ec=%b cnt=%0d expected 1 01 1", obs_err, obs_ec, obs_cnt);
      end
      do_start(1'b0);
      send_op(1'b0, ADDI, 5'd3, 5'd1, 5'd0, 13'h1800, 1'b1, 32'h80008193, w);
      send_op(1'b0, ADDI, 5'd3, 5'd1, 5'd0, 13'h07FF, 1'b1, 32'h7FF08193, w);
      send_op(1'b0, LW, 5'd3, 5'd1, 5'd0, 13'h17FF, 1'b0, 32'h0, w);
      checks++;
      if ({obs_err, obs_ec, obs_cnt} !== {1'b1, 2'b01, 9'd2}) begin
         failures++;
         $display("FAIL lw_range_err: got err=%b ec=%b cnt=%0d expected 1 01 2", obs_err, obs_ec, obs_cnt);
      end
   endtask

   task automatic test_full();
      int w;
      do_start(1'b1);
      send_op(1'b1, ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3, w);
      send_op(1'b1, ADD, 5'd4, 5'd1, 5'd2, 13'd0, 1'b1, 32'h00208233, w);
      send_op(1'b1, ADD, 5'd5, 5'd1, 5'd2, 13'd0, 1'b0, 32'h0, w);
      checks++;
      if ({obs_done, obs_err, obs_ec, obs_cnt} !== {1'b0, 1'b1, 2'b10, 9'd2}) begin
         failures++;
         $display("FAIL full_err: got done=%b err=%b ec=%b cnt=%0d expected 0 1 10 2", obs_done, obs_err, obs_ec, obs_cnt);
      end
      do_start(1'b1);
      send_op(1'b1, ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3, w);
      send_op(1'b1, ADD, 5'd4, 5'd1, 5'd2, 13'd0, 1'b1, 32'h00208233, w);
      send_op(1'b1, ENDO, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'h0, w);
      checks++;
      if ({obs_done, obs_err, obs_ec, obs_cnt, obs_addr} !== {1'b1, 1'b0, 2'b00, 9'd2, 8'd2}) begin
         failures++;
         $display("FAIL full_then_end: got done=%b err=%b ec=%b cnt=%0d addr=%0d expected 1 0 00 2 2",
                  obs_done, obs_err, obs_ec, obs_cnt, obs_addr);
      end
   endtask

   task automatic test_back_to_back();
      int          w;
      logic [11:0] iv;
      logic [4:0]  rdv;
      do_start(1'b0);
      for (int i = 0; i < 4; i++) begin
         iv  = 12'(i * 3);
         rdv = 5'(i + 1);
         send_op(1'b0, ADDI, rdv, 5'd0, 5'd0, {iv[11], iv}, 1'b1,
                 {iv, 5'd0, 3'b000, rdv, 7'b0010011}, w);
         checks++;
         if (w !== ((i == 0) ? 0 : 1)) begin
            failures++;
            $display("FAIL b2b_ready_gap: op %0d waited %0d cycles expected %0d", i, w, (i == 0) ? 0 : 1);
         end
      end
      send_op(1'b0, ENDO, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'h0, w);
   endtask

   task automatic test_reset_mid_write();
      do_start(1'b0);
      op_code = ADD; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 13'd0;
      op_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ifa.mem_we !== 1'b1) begin
         failures++;
         $display("FAIL write_before_rst: mem_we got %b expected 1", ifa.mem_we);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ifa.op_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, busy_a, done_a, err_a, ec_a, cnt_a} !== '0) begin
         failures++;
         $display("FAIL rst_mid_write: got rdy=%b we=%b addr=%0d wdata=%h busy=%b cnt=%0d expected all 0",
                  ifa.op_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, busy_a, cnt_a);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifa.op_ready, ifa.mem_we, busy_a} !== 3'b000) begin
         failures++;
         $display("FAIL post_rst_idle: got rdy=%b we=%b busy=%b expected 0 0 0", ifa.op_ready, ifa.mem_we, busy_a);
      end
      op_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_branch();
      test_imm_errors();
      test_full();
      test_back_to_back();
      test_reset_mid_write();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d writes outstanding expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential RV32I instruction encoder and program loader: the producer counterpart of the Control decoder.
- Accepts symbolic micro-ops over a valid/ready handshake and encodes them into 32-bit words for ADD, XOR, SLL, ADDI, LW, SW and BNE.
- Writes each word to consecutive instruction-memory addresses.
- Used for self-loading test programs and bring-up of the single-cycle core; sits between a stimulus source and the instruction-memory write port.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, maximum number of words loaded (must be ≤ 2^ADDR_W).
- BASE, 0, word address of the first write.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begins a load session; honoured only in IDLE, DONE or ERROR.
- op_valid  in  1  micro-op present.
- op_ready  out  1  encoder can accept a micro-op.
- op_code  in  3  000 ADD, 001 XOR, 010 SLL, 011 ADDI, 100 LW, 101 SW, 110 BNE, 111 END.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  13  signed immediate (two's complement).
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  high in ACCEPT and WRITE.
- done  out  1  level; load session finished by END.
- err  out  1  level; session aborted.
- err_code  out  2  00 none, 01 immediate out of range, 10 program full.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; mem_addr=BASE; no write issued even if asserted mid-WRITE.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start=1 → ACCEPT. On that transition, clear count, done, err and err_code; set mem_addr=BASE. start is ignored in ACCEPT/WRITE.
- ACCEPT: op_ready=1. On op_valid & op_ready, decode op_code:
  - END → DONE, no write.
  - count==DEPTH → ERROR, err_code=10.
  - immediate illegal → ERROR, err_code=01.
  - otherwise register the encoded word into mem_wdata → WRITE.
- WRITE: mem_we=1 for exactly one cycle at the current mem_addr. Next cycle: mem_addr+1, count+1 → ACCEPT.
- Timing: handshake in cycle N, mem_we in N+1, op_ready again in N+2. Maximum rate is one op per 2 cycles.
- Immediate rules:
  - ADDI/LW/SW: imm must lie in −2048..2047.
  - BNE: imm must lie in −4096..4094 and be even (imm[0]=0).
  - R-type ops: imm is ignored.
  - rd=0 is legal (encoded as-is).
- Encodings (bit fields MSB→LSB):
  - R-type: {funct7=0000000, rs2, rs1, funct3, rd, 0110011}; funct3 is ADD 000, XOR 100, SLL 001.
  - ADDI: {imm[11:0], rs1, 000, rd, 0010011}.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BNE: {imm[12], imm[10:5], rs2, rs1, 001, imm[4:1], imm[11], 1100011}.
- count == DEPTH followed by END → DONE (full is not an error unless another op arrives).
- mem_addr wraps modulo 2^ADDR_W. This is only reachable if BASE+DEPTH > 2^ADDR_W, which is a legal configuration with wrap.
- While in DONE/ERROR, mem_wdata and mem_addr hold their last values; op_ready=0.

Test Plan:
- start; ADD rd3,rs1,rs2=2 → mem_wdata 0x002081B3 @addr0; XOR same regs → 0x0020C1B3 @addr1; END → done=1, count=2.
- ADDI rd3,rs1,7 → 0x00708193; LW rd2,0(x0) → 0x00002103; SW rs2=2,4(x0) → 0x00202223; addresses 0,1,2 in order.
- BNE rs1=1,rs2=2 imm=0 → 0x00209063; imm=−4 (0x1FFC) → 0xFE209EE3.
- ADDI imm=2048 → err=1, err_code=01, no mem_we; BNE imm=3 → err_code=01; start then clears err and restarts at addr0.
- DEPTH=2: two ADDs written, third ADD → err_code=10, count=2; separately END at count=2 → done.
- Assert rst during WRITE: mem_we drops asynchronously, all outputs 0, state IDLE; op_valid held high with no start → op_ready stays 0.
